div_row_normalizer: RTL and testbench

Row-normalization sequencer for the softmax output stage. It accepts one row of N accumulated numerators plus the shared row-sum denominator. It issues the N numerator/denominator pairs one at a time to an `int_division` instance over that divider's valid/ready handshake, then collects the returned quotients in order. When the row is complete, it presents the full quotient vector downstream.

---
 rtl/div_row_normalizer.sv | 152 +++++++++++++++
 tb/tb_div_row_normalizer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_row_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : div_row_normalizer
//  Description : Softmax row-normalization sequencer. Captures a row of N
//                numerators plus a shared denominator, streams the pairs to
//                an external divider over valid/ready, gathers the in-order
//                quotients and presents the complete quotient vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_row_normalizer #(
    parameter int N        = 8,                 // elements per row, >= 2
    parameter int DIV_IN_W = 16,                // $bits(DIV_INPUT_QT)
    parameter int QUOT_W   = 16,                // $bits(OUTPUT_VEC_QT)
    parameter int IDX_W    = $clog2(N + 1)      // issue/return counter width
) (
    input  logic                  clk,
    input  logic                  rst,
    // upstream row
    input  logic                  vld_in,
    output logic                  rdy_out,
    input  logic [N*DIV_IN_W-1:0] numerator_vec_in,
    input  logic [DIV_IN_W-1:0]   denominator_in,
    // divider request side
    output logic                  div_vld,
    input  logic                  div_rdy,
    output logic [DIV_IN_W-1:0]   div_numerator,
    output logic [DIV_IN_W-1:0]   div_denominator,
    // divider result side
    input  logic                  div_quot_vld,
    output logic                  div_quot_rdy,
    input  logic [QUOT_W-1:0]     div_quotient,
    // downstream row
    output logic                  vld_out,
    input  logic                  rdy_in,
    output logic [N*QUOT_W-1:0]   quotient_vec_out
);

    localparam logic [IDX_W-1:0] c_row_len  = IDX_W'(N);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [N*DIV_IN_W-1:0] r_num_vec;
    logic [DIV_IN_W-1:0]   r_den;
    logic [IDX_W-1:0]      r_iss;
    logic [IDX_W-1:0]      r_ret;
    logic [N*QUOT_W-1:0]   r_qbuf;

    logic                  w_capture;
    logic                  w_issue_fire;
    logic                  w_ret_fire;
    logic [DIV_IN_W-1:0]   w_num_sel;

    // Handshake strobes and outputs, all decoded from registered state
    assign rdy_out          = (r_state == S_IDLE);
    assign div_vld          = (r_state == S_RUN) && (r_iss < c_row_len);
    assign div_quot_rdy     = (r_state == S_RUN) && (r_ret < c_row_len);
    assign vld_out          = (r_state == S_OUT);
    assign quotient_vec_out = r_qbuf;

    assign w_capture    = vld_in && rdy_out;
    assign w_issue_fire = div_vld && div_rdy;
    assign w_ret_fire   = div_quot_vld && div_quot_rdy;

    // Select stored numerator[iss]; idle request lines are driven to zero
    always_comb begin
        w_num_sel = '0;
        if (div_vld) begin
            for (int i = 0; i < N; i++) begin
                if (r_iss == IDX_W'(i)) begin
                    w_num_sel = r_num_vec[i*DIV_IN_W +: DIV_IN_W];
                end
            end
        end
    end

    assign div_numerator   = w_num_sel;
    assign div_denominator = div_vld ? r_den : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: leave RUN on the final quotient handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_ret_fire && (r_ret == c_last_idx)) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (rdy_in) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Row capture and issue counter; issue side runs independently of returns
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_vec <= '0;
            r_den     <= '0;
            r_iss     <= '0;
        end else if (w_capture) begin
            r_num_vec <= numerator_vec_in;
            r_den     <= denominator_in;
            r_iss     <= '0;
        end else if (w_issue_fire) begin
            r_iss     <= r_iss + IDX_W'(1);
        end
    end

    // Return counter and quotient buffer; in-order results land in slot ret
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ret  <= '0;
            r_qbuf <= '0;
        end else if (w_capture) begin
            r_ret  <= '0;
        end else if (w_ret_fire) begin
            r_ret <= r_ret + IDX_W'(1);
            for (int i = 0; i < N; i++) begin
                if (r_ret == IDX_W'(i)) begin
                    r_qbuf[i*QUOT_W +: QUOT_W] <= div_quotient;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_row_normalizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_div_row_normalizer
//  Description : Scoreboard bench for div_row_normalizer (N=4) with a
//                fixed-latency (L=3) stub divider returning tags, or
//                saturated values on a zero denominator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_row_normalizer;

    localparam int N = 4;
    localparam int W = 16;
    localparam int Q = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           vld_in;
    logic           rdy_out;
    logic [N*W-1:0] numerator_vec_in;
    logic [W-1:0]   denominator_in;
    logic           div_vld;
    logic           div_rdy;
    logic [W-1:0]   div_numerator;
    logic [W-1:0]   div_denominator;
    logic           div_quot_vld;
    logic           div_quot_rdy;
    logic [Q-1:0]   div_quotient;
    logic           vld_out;
    logic           rdy_in;
    logic [N*Q-1:0] quotient_vec_out;

    always #5 clk = ~clk;

    div_row_normalizer #(
        .N        (N),
        .DIV_IN_W (W),
        .QUOT_W   (Q)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .vld_in           (vld_in),
        .rdy_out          (rdy_out),
        .numerator_vec_in (numerator_vec_in),
        .denominator_in   (denominator_in),
        .div_vld          (div_vld),
        .div_rdy          (div_rdy),
        .div_numerator    (div_numerator),
        .div_denominator  (div_denominator),
        .div_quot_vld     (div_quot_vld),
        .div_quot_rdy     (div_quot_rdy),
        .div_quotient     (div_quotient),
        .vld_out          (vld_out),
        .rdy_in           (rdy_in),
        .quotient_vec_out (quotient_vec_out)
    );

    // ---------------- shared bookkeeping ----------------
    int cyc = 0;
    int tag_base = 0;
    int iss_cnt = 0;
    int ret_cnt = 0;
    int tot_cnt = 0;
    int pass_cnt = 0;
    int extra_fail = 0;
    int b2b_idx = 0;

    logic [31:0] exp_iss[$];
    logic [63:0] exp_out[$];
    int          exp_lat[$];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stub divider, latency 3 ----------------
    logic [2:0]   st_v;
    logic [Q-1:0] st_d0, st_d1, st_d2;

    function automatic logic [Q-1:0] stub_res(input logic [W-1:0] num, input logic [W-1:0] den,
                                              input int base, input int idx);
        if (den == '0) begin
            if ($signed(num) < 0) return 16'h8000;
            return 16'h7FFF;
        end
        return Q'(base + idx - 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            st_v  <= '0;
            st_d0 <= '0;
            st_d1 <= '0;
            st_d2 <= '0;
        end else begin
            st_v  <= {st_v[1:0], div_vld & div_rdy};
            st_d0 <= stub_res(div_numerator, div_denominator, tag_base, iss_cnt);
            st_d1 <= st_d0;
            st_d2 <= st_d1;
        end
    end

    assign div_quot_vld = st_v[2];
    assign div_quotient = st_d2;

    // ---------------- comparison helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        tot_cnt++;
        $display("FAIL %s: got %h required nothing (cycle %0d)", name, act, cyc);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        prev_rst = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pair = '0;
    logic        prev_vld_out = 1'b0;
    logic [63:0] prev_vec = '0;
    logic        prev_out_hs = 1'b0;
    int          cap_cyc = 0;
    int          cap_num = 0;
    int          last_out_cyc = 0;
    logic [31:0] pair_e;
    logic [63:0] vec_e;
    int          lat_e;

    always @(negedge clk) begin
        if (rst) begin
            iss_cnt      = 0;
            ret_cnt      = 0;
            prev_stall   = 1'b0;
            prev_vld_out = 1'b0;
            prev_out_hs  = 1'b0;
        end else begin
            if (prev_rst) begin
                chk("rst_rdy_out",  64'(rdy_out), 64'd1);
                chk("rst_div_vld",  64'(div_vld), 64'd0);
                chk("rst_quot_rdy", 64'(div_quot_rdy), 64'd0);
                chk("rst_vld_out",  64'(vld_out), 64'd0);
                chk("rst_div_num",  64'(div_numerator), 64'd0);
                chk("rst_div_den",  64'(div_denominator), 64'd0);
                chk("rst_vec",      64'(quotient_vec_out), 64'd0);
            end
            if (vld_in && rdy_out) begin
                cap_num++;
                cap_cyc = cyc;
                iss_cnt = 0;
                ret_cnt = 0;
                if (cap_num == b2b_idx) chk("b2b_gap", 64'(cyc - last_out_cyc), 64'd1);
            end
            if (prev_stall) begin
                chk("stall_div_vld", 64'(div_vld), 64'd1);
                chk("stall_pair", 64'({div_numerator, div_denominator}), 64'(prev_pair));
            end
            if (div_vld && div_rdy) begin
                if (exp_iss.size() == 0) begin
                    fail_now("issue_extra", 64'({div_numerator, div_denominator}));
                end else begin
                    pair_e = exp_iss.pop_front();
                    chk("issue_pair", 64'({div_numerator, div_denominator}), 64'(pair_e));
                end
                iss_cnt++;
            end
            if (div_quot_vld) begin
                chk("quot_rdy", 64'(div_quot_rdy), 64'd1);
                if (div_quot_rdy) ret_cnt++;
            end
            if (vld_out && !prev_vld_out) begin
                if (exp_lat.size() == 0) begin
                    fail_now("vld_out_extra", 64'(quotient_vec_out));
                end else begin
                    lat_e = exp_lat.pop_front();
                    chk("latency", 64'(cyc - cap_cyc), 64'(lat_e));
                end
            end
            if (vld_out) begin
                chk("out_rdy_out", 64'(rdy_out), 64'd0);
                chk("out_quot_rdy", 64'(div_quot_rdy), 64'd0);
                if (prev_vld_out) chk("out_hold", 64'(quotient_vec_out), prev_vec);
            end
            if (prev_out_hs) chk("turnaround_rdy_out", 64'(rdy_out), 64'd1);
            if (vld_out && rdy_in) begin
                if (exp_out.size() == 0) begin
                    fail_now("row_extra", 64'(quotient_vec_out));
                end else begin
                    vec_e = exp_out.pop_front();
                    chk("row_vec", 64'(quotient_vec_out), vec_e);
                end
                last_out_cyc = cyc;
            end
            prev_stall   = div_vld && !div_rdy;
            prev_pair    = {div_numerator, div_denominator};
            prev_vld_out = vld_out;
            prev_vec     = 64'(quotient_vec_out);
            prev_out_hs  = vld_out && rdy_in;
        end
        prev_rst = rst;
    end

    // ---------------- stimulus ----------------
    task automatic expect_row(input logic [63:0] nv, input logic [15:0] den,
                              input logic [63:0] vec, input int lat, input int n_iss);
        for (int i = 0; i < n_iss; i++) exp_iss.push_back({nv[i*16 +: 16], den});
        if (n_iss == N) begin
            exp_out.push_back(vec);
            exp_lat.push_back(lat);
        end
    endtask

    task automatic timeout(input string name);
        extra_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    task automatic send_row(input logic [63:0] nv, input logic [15:0] den,
                            input int base, input logic keep_vld);
        logic fired;
        fired            = 1'b0;
        tag_base         = base;
        numerator_vec_in = nv;
        denominator_in   = den;
        vld_in           = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rdy_out) begin
                fired = 1'b1;
                break;
            end
        end
        if (!fired) timeout("capture_wait");
        @(posedge clk);
        #1;
        if (!keep_vld) vld_in = 1'b0;
    endtask

    task automatic wait_iss(input int n);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (iss_cnt >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) timeout("issue_wait");
    endtask

    task automatic wait_ret(input int n);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (ret_cnt >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) timeout("return_wait");
    endtask

    task automatic wait_vld_out();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (vld_out) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) timeout("vld_out_wait");
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_out.size() == 0 && rdy_out) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("row_done_wait");
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        vld_in           = 1'b0;
        rdy_in           = 1'b1;
        div_rdy          = 1'b1;
        numerator_vec_in = '0;
        denominator_in   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // basic row: {0.0, 0.5, 1.0, 0.75} / 2.0 (Q8.8), tags 10..13
        expect_row(64'h00C0_0100_0080_0000, 16'h0200, 64'h000D_000C_000B_000A, 8, N);
        send_row(64'h00C0_0100_0080_0000, 16'h0200, 10, 1'b0);
        wait_done();

        // divider backpressure: 5 stalled cycles after the second issue
        expect_row(64'h0100_00C0_0080_0040, 16'h0100, 64'h0017_0016_0015_0014, 13, N);
        send_row(64'h0100_00C0_0080_0040, 16'h0100, 20, 1'b0);
        wait_iss(2);
        div_rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1 div_rdy = 1'b1;
        wait_done();

        // downstream stall: 10 cycles in OUT with rdy_in low
        rdy_in = 1'b0;
        expect_row(64'h0004_0003_0002_0001, 16'h0300, 64'h0021_0020_001F_001E, 8, N);
        send_row(64'h0004_0003_0002_0001, 16'h0300, 30, 1'b0);
        wait_vld_out();
        repeat (10) @(posedge clk);
        #1 rdy_in = 1'b1;
        wait_done();

        // zero denominator: {1.0, -1.0, 0, 0} / 0 -> saturated values untouched
        expect_row(64'h0000_0000_FF00_0100, 16'h0000, 64'h7FFF_7FFF_8000_7FFF, 8, N);
        send_row(64'h0000_0000_FF00_0100, 16'h0000, 0, 1'b0);
        wait_done();

        // reset mid-row: two issues, one return, then a one-cycle reset
        expect_row(64'h0008_0007_0006_0005, 16'h0100, 64'h0, 0, 2);
        send_row(64'h0008_0007_0006_0005, 16'h0100, 40, 1'b0);
        wait_iss(2);
        div_rdy = 1'b0;
        wait_ret(1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        div_rdy = 1'b1;
        expect_row(64'h1111_2222_3333_4444, 16'h0400, 64'h0035_0034_0033_0032, 8, N);
        send_row(64'h1111_2222_3333_4444, 16'h0400, 50, 1'b0);
        wait_done();

        // back-to-back rows with vld_in held high; second capture is the 8th
        b2b_idx = 8;
        expect_row(64'h0044_0033_0022_0011, 16'h0100, 64'h003F_003E_003D_003C, 8, N);
        expect_row(64'h0088_0077_0066_0055, 16'h0200, 64'h0049_0048_0047_0046, 8, N);
        send_row(64'h0044_0033_0022_0011, 16'h0100, 60, 1'b1);
        wait_iss(4);
        send_row(64'h0088_0077_0066_0055, 16'h0200, 70, 1'b0);
        wait_done();

        repeat (5) @(posedge clk);
        if (exp_iss.size() != 0 || exp_out.size() != 0 || exp_lat.size() != 0) begin
            extra_fail++;
            $display("FAIL scoreboard_drain: issues %0d rows %0d latencies %0d still pending",
                     exp_iss.size(), exp_out.size(), exp_lat.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt + extra_fail);
        $finish;
    end

endmodule
`default_nettype wire
